// File: rtl/out_fifo.sv
// Output FIFO buffering core accumulator words for a downstream consumer.
// Circular buffer with a registered occupancy count and a sticky overflow flag.
module out_fifo #(
  parameter int NBITS      = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [NBITS-1:0]      wr_data,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [NBITS-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  clr_ovf
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [NBITS-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  push, pop, drop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_CNT);
  assign rd_valid = !empty;
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;
  assign overflow = overflow_q;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  always_comb begin
    pop  = rd_valid && rd_ready;
    push = wr_en && (!full || pop);
    drop = wr_en && !push;

    wr_ptr_d = push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      default: count_d = count_q;
    endcase

    overflow_d = overflow_q;
    if (drop)
      overflow_d = 1'b1;
    else if (clr_ovf)
      overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; stale entries stay hidden behind count/rd_valid.
  always_ff @(posedge clk) begin
    if (rst_n && push)
      mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_out_fifo.sv
// Self-checking bench for out_fifo: directed vector table, corner-case
// sequences, and randomized traffic against a queue-based reference model.
module tb_out_fifo;

  localparam int NBITS = 16;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [NBITS-1:0] wr_data = '0;
  logic             rd_ready = 1'b0;
  logic             clr_ovf = 1'b0;
  logic             rd_valid;
  logic [NBITS-1:0] rd_data;
  logic             full;
  logic             empty;
  logic [3:0]       count;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  logic [NBITS-1:0] model_q[$];
  logic             model_ovf = 1'b0;

  out_fifo #(.NBITS(NBITS), .DEPTH_LOG2(3)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, wr_en;
    logic [15:0] wr_data;
    logic        rd_ready, clr_ovf;
    logic [3:0]  e_count;
    logic        e_valid;
    logic [15:0] e_data;
    logic        e_full, e_empty, e_ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the reference model at the edge,
  // and leave the bench #1 past the edge for sampling.
  task automatic applyStimulus(input logic rn, input logic we, input logic [15:0] wd,
                               input logic rr, input logic co);
    bit m_pop, m_push, m_full;
    rst_n = rn; wr_en = we; wr_data = wd; rd_ready = rr; clr_ovf = co;
    @(posedge clk);
    if (!rn) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      m_full = (model_q.size() == DEPTH);
      m_pop  = (model_q.size() > 0) && rr;
      m_push = we && (!m_full || m_pop);
      if (m_pop) void'(model_q.pop_front());
      if (m_push) model_q.push_back(wd);
      if (we && !m_push) model_ovf = 1'b1;
      else if (co) model_ovf = 1'b0;
    end
    #1;
  endtask

  task automatic checkOutput(input string name);
    int sz;
    sz = model_q.size();
    check({name, " count"},    int'(count),    sz);
    check({name, " empty"},    int'(empty),    int'(sz == 0));
    check({name, " full"},     int'(full),     int'(sz == DEPTH));
    check({name, " rd_valid"}, int'(rd_valid), int'(sz != 0));
    check({name, " rd_data"},  int'(rd_data),  (sz != 0) ? int'(model_q[0]) : 0);
    check({name, " overflow"}, int'(overflow), int'(model_ovf));
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    // rst wr data rr clr | count valid data full empty ovf
    vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 4'd1, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 16'h0002, 1'b0, 1'b0, 4'd2, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 16'h0003, 1'b0, 1'b0, 4'd3, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd2, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 16'h0004, 1'b1, 1'b0, 4'd2, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd1, 1'b1, 16'h0004, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 16'h0005, 1'b1, 1'b0, 4'd1, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 16'h0009, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};

    #2;
    for (int i = 0; i < 11; i++) begin
      string n;
      n = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].rst_n, vecs[i].wr_en, vecs[i].wr_data, vecs[i].rd_ready, vecs[i].clr_ovf);
      check({n, " count"},    int'(count),    int'(vecs[i].e_count));
      check({n, " rd_valid"}, int'(rd_valid), int'(vecs[i].e_valid));
      check({n, " rd_data"},  int'(rd_data),  int'(vecs[i].e_data));
      check({n, " full"},     int'(full),     int'(vecs[i].e_full));
      check({n, " empty"},    int'(empty),    int'(vecs[i].e_empty));
      check({n, " overflow"}, int'(overflow), int'(vecs[i].e_ovf));
    end

    // Fill, drop a ninth word, drain in order.
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 16'h00A0 + 16'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h00FF, 1'b0, 1'b0);
    check("ovf9 full", int'(full), 1);
    check("ovf9 overflow", int'(overflow), 1);
    check("ovf9 count", int'(count), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d data", i), int'(rd_data), 'hA0 + i);
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    end
    check("drain empty", int'(empty), 1);
    check("drain rd_data", int'(rd_data), 0);
    checkOutput("drain model");

    // Full FIFO with simultaneous push and pop.
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 16'h0010 + 16'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h1234, 1'b1, 1'b0);
    check("fullpp count", int'(count), 8);
    check("fullpp overflow", int'(overflow), 0);
    check("fullpp head", int'(rd_data), 'h11);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    check("fullpp tail", int'(rd_data), 'h1234);
    check("fullpp last count", int'(count), 1);

    // Sticky overflow versus clr_ovf.
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 16'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b0);
    check("sticky set", int'(overflow), 1);
    idle();
    check("sticky hold", int'(overflow), 1);
    applyStimulus(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b1);
    check("clr+drop", int'(overflow), 1);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    check("clr alone", int'(overflow), 0);
    check("clr count", int'(count), 8);

    // Streaming through with rd_ready held: pointers wrap twice.
    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, 16'(i), 1'b1, 1'b0);
      check($sformatf("stream%0d data", i), int'(rd_data), i);
      check($sformatf("stream%0d cnt<=1", i), int'(count <= 4'd1), 1);
    end
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    check("stream end empty", int'(empty), 1);

    // Mid-operation reset with a concurrent write.
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 16'h0050 + 16'(i), 1'b0, 1'b0);
    check("pre-rst count", int'(count), 5);
    applyStimulus(1'b0, 1'b1, 16'h7777, 1'b0, 1'b0);
    check("midrst count", int'(count), 0);
    check("midrst empty", int'(empty), 1);
    check("midrst rd_valid", int'(rd_valid), 0);
    check("midrst overflow", int'(overflow), 0);
    idle();
    check("midrst no write", int'(count), 0);
    applyStimulus(1'b1, 1'b1, 16'h0042, 1'b0, 1'b0);
    check("postrst data", int'(rd_data), 'h42);

    // Randomized traffic; read pressure varies per phase to reach full and empty.
    doReset();
    for (int ph = 0; ph < 15; ph++) begin
      int rr_pct, wr_pct;
      rr_pct = $urandom_range(5, 95);
      wr_pct = $urandom_range(5, 95);
      for (int c = 0; c < 150; c++) begin
        logic rn, we, rr, co;
        rn = ($urandom_range(0, 199) != 0);
        we = ($urandom_range(0, 99) < wr_pct);
        rr = ($urandom_range(0, 99) < rr_pct);
        co = ($urandom_range(0, 15) == 0);
        applyStimulus(rn, we, 16'($urandom), rr, co);
        checkOutput($sformatf("rand p%0d c%0d", ph, c));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
